// File: rtl/sdram_port_arb.sv
// Two-port SDRAM arbiter: a loader write port and a cassette read port share one
// single-command controller through 1-entry holders, with fair grant and timeout.
module sdram_port_arb #(
    parameter int ADDR_W = 25,
    parameter int TMO    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ovf,
    input  logic              cs_rd,
    input  logic [ADDR_W-1:0] cs_addr,
    output logic [7:0]        cs_data,
    output logic              cs_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic              mem_ready,
    output logic              err_tmo
);

    typedef enum logic [2:0] {IDLE, WR_ISS, WR_WAIT, RD_ISS, RD_WAIT} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wr_addr, rd_addr, last_addr;
    logic [7:0]        wr_data, last_din;
    logic              wr_pend, rd_pend;
    logic              last_grant;   // 1 = write port won the previous grant
    logic [7:0]        cnt;
    logic              in_wait, tmo_hit;

    assign in_wait = (state == WR_WAIT) || (state == RD_WAIT);
    // Counter starts at 0 in the first WAIT cycle, so TMO-1 marks the last allowed one.
    assign tmo_hit = in_wait && (cnt == 8'(TMO - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (wr_pend && (!rd_pend || !last_grant))
                    state_nx = WR_ISS;
                else if (rd_pend)
                    state_nx = RD_ISS;
            end
            WR_ISS:  state_nx = WR_WAIT;
            RD_ISS:  state_nx = RD_WAIT;
            WR_WAIT,
            RD_WAIT: if (mem_ready || tmo_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Commands come straight off the state; between commands the bus shows the last issue.
    assign mem_we   = (state == WR_ISS);
    assign mem_rd   = (state == RD_ISS);
    assign mem_addr = (state == WR_ISS) ? wr_addr :
                      (state == RD_ISS) ? rd_addr : last_addr;
    assign mem_din  = (state == WR_ISS) ? wr_data : last_din;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_pend    <= 1'b0;
            rd_addr    <= '0;
            rd_pend    <= 1'b0;
            last_addr  <= '0;
            last_din   <= '0;
            last_grant <= 1'b0;
            cnt        <= '0;
            ld_ovf     <= 1'b0;
            err_tmo    <= 1'b0;
            cs_ack     <= 1'b0;
            cs_data    <= '0;
        end else begin
            state <= state_nx;

            if (state == WR_ISS || state == RD_ISS)
                cnt <= '0;
            else if (in_wait)
                cnt <= cnt + 8'd1;

            if (state == WR_ISS) begin
                last_addr <= wr_addr;
                last_din  <= wr_data;
            end else if (state == RD_ISS) begin
                last_addr <= rd_addr;
            end

            if (state == IDLE && state_nx == WR_ISS) last_grant <= 1'b1;
            if (state == IDLE && state_nx == RD_ISS) last_grant <= 1'b0;

            // A write landing on the issue cycle refills the slot being emptied.
            if (ld_wr && (!wr_pend || state == WR_ISS)) begin
                wr_addr <= ld_addr;
                wr_data <= ld_data;
                wr_pend <= 1'b1;
            end else if (state == WR_ISS) begin
                wr_pend <= 1'b0;
            end
            if (ld_wr && wr_pend && state != WR_ISS)
                ld_ovf <= 1'b1;

            if (cs_rd) begin
                rd_addr <= cs_addr;
                rd_pend <= 1'b1;
            end else if (state == RD_ISS) begin
                rd_pend <= 1'b0;
            end

            cs_ack <= 1'b0;
            if (state == RD_WAIT && mem_ready) begin
                cs_ack  <= 1'b1;
                cs_data <= mem_dout;
            end else if (state == RD_WAIT && tmo_hit) begin
                cs_ack  <= 1'b1;
                cs_data <= 8'hFF;
            end

            if (tmo_hit && !mem_ready)
                err_tmo <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: directed vector table, hand sequences for multi-cycle
// corners, then random traffic against a transaction-level model with a reactive memory.
module tb_sdram_port_arb;
    localparam int AW  = 25;
    localparam int TMO = 8;

    logic          clk = 1'b0, reset = 1'b0;
    logic          ld_wr = 1'b0, cs_rd = 1'b0, mem_ready = 1'b0;
    logic [AW-1:0] ld_addr = '0, cs_addr = '0;
    logic [7:0]    ld_data = '0, mem_dout = '0;
    logic          ld_ovf, cs_ack, mem_we, mem_rd, err_tmo;
    logic [7:0]    cs_data, mem_din;
    logic [AW-1:0] mem_addr;

    sdram_port_arb #(.ADDR_W(AW), .TMO(TMO)) dut (
        .clk(clk), .reset(reset),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ovf(ld_ovf),
        .cs_rd(cs_rd), .cs_addr(cs_addr), .cs_data(cs_data), .cs_ack(cs_ack),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_ready(mem_ready), .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ovf"},    32'(ld_ovf),   0);
        chk({tag, "_tmo"},    32'(err_tmo),  0);
        chk({tag, "_ack"},    32'(cs_ack),   0);
        chk({tag, "_data"},   32'(cs_data),  0);
        chk({tag, "_we"},     32'(mem_we),   0);
        chk({tag, "_rd"},     32'(mem_rd),   0);
        chk({tag, "_addr"},   32'(mem_addr), 0);
        chk({tag, "_din"},    32'(mem_din),  0);
    endtask

    task automatic do_reset();
        reset = 1'b0; ld_wr = 1'b0; cs_rd = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic wait_cmd(output bit is_wr, output bit ok);
        is_wr = 1'b0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_we || mem_rd) begin
                is_wr = mem_we; ok = 1'b1;
                return;
            end
            tick();
        end
        chk("cmd_wait_expired", 0, 1);
    endtask

    // Complete the current command with mem_ready in its first WAIT cycle.
    task automatic finish_cmd();
        tick(); mem_ready = 1'b1;
        tick(); mem_ready = 1'b0;
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;      // write data, or mem_dout returned for a read
        int            dly;       // WAIT cycle (1-based) carrying mem_ready; 0 = never
        bit            exp_ack;
        logic [7:0]    exp_data;
        bit            exp_tmo;
    } vec_t;
    vec_t tbl[6];

    // ---------------- random-phase reference model ----------------
    bit            wpend_m, rpend_m, ovf_m, tmo_m, last_wr_m, prev_w, prev_r, cmd_rd_m;
    logic [AW-1:0] w_addr_m, r_addr_m, last_addr_m;
    logic [7:0]    w_data_m, last_din_m, ack_exp;
    int            cmd_c, cmd_d, cmd_e, ack_due, tmo_cyc;

    task automatic model_init();
        wpend_m = 0; rpend_m = 0; ovf_m = 0; tmo_m = 0; last_wr_m = 0;
        prev_w = 0; prev_r = 0; cmd_rd_m = 0;
        w_addr_m = '0; r_addr_m = '0; last_addr_m = '0; w_data_m = '0; last_din_m = '0;
        ack_exp = '0; cmd_c = -100; cmd_d = 1; cmd_e = -100; ack_due = -1; tmo_cyc = -1;
    endtask

    task automatic rnd_cycle(input bit allow);
        int n;
        bit cur_w, cur_r;
        n = cyc; cur_w = wpend_m; cur_r = rpend_m;
        if (n == tmo_cyc) tmo_m = 1;
        chk("rnd_ack", 32'(cs_ack), 32'(n == ack_due));
        if (cs_ack && n == ack_due) chk("rnd_ack_data", 32'(cs_data), 32'(ack_exp));
        chk("rnd_ovf", 32'(ld_ovf), 32'(ovf_m));
        chk("rnd_tmo", 32'(err_tmo), 32'(tmo_m));
        chk("rnd_one_cmd", 32'(mem_we & mem_rd), 0);
        if (mem_we || mem_rd) begin
            chk("rnd_idle_gap", 32'(n >= cmd_e + 2), 1);
            if (prev_w && prev_r) chk("rnd_grant", 32'(mem_we), 32'(!last_wr_m));
            last_wr_m = mem_we;
            if (mem_we) begin
                chk("rnd_we_pend", 32'(wpend_m), 1);
                chk("rnd_we_addr", 32'(mem_addr), 32'(w_addr_m));
                chk("rnd_we_din",  32'(mem_din),  32'(w_data_m));
                wpend_m = 0; last_addr_m = w_addr_m; last_din_m = w_data_m;
            end else begin
                chk("rnd_rd_pend", 32'(rpend_m), 1);
                chk("rnd_rd_addr", 32'(mem_addr), 32'(r_addr_m));
                rpend_m = 0; last_addr_m = r_addr_m;
            end
            cmd_rd_m = mem_rd;
            cmd_c = n;
            cmd_d = int'($urandom_range(1, TMO + 2));
            cmd_e = (cmd_d <= TMO) ? n + cmd_d : n + TMO;
            if (mem_rd) begin
                ack_due = (cmd_d <= TMO) ? n + cmd_d + 1 : n + TMO + 1;
                ack_exp = (cmd_d <= TMO) ? 8'($urandom) : 8'hFF;
            end
            if (cmd_d > TMO) tmo_cyc = n + TMO + 1;
        end else begin
            chk("rnd_addr_hold", 32'(mem_addr), 32'(last_addr_m));
            chk("rnd_din_hold",  32'(mem_din),  32'(last_din_m));
        end
        // memory side: answer on schedule, otherwise throw stray pulses outside WAIT
        if (n == cmd_c + cmd_d && cmd_d <= TMO) begin
            mem_ready = 1'b1;
            mem_dout  = cmd_rd_m ? ack_exp : 8'($urandom);
        end else if (n > cmd_e || n == cmd_c) begin
            mem_ready = ($urandom_range(0, 7) == 0);
            mem_dout  = 8'($urandom);
        end else begin
            mem_ready = 1'b0;
        end
        ld_wr   = allow && ($urandom_range(0, 4) == 0);
        ld_addr = AW'($urandom);
        ld_data = 8'($urandom);
        cs_rd   = allow && ($urandom_range(0, 4) == 0);
        cs_addr = AW'($urandom);
        if (ld_wr) begin
            if (wpend_m) ovf_m = 1;
            else begin wpend_m = 1; w_addr_m = ld_addr; w_data_m = ld_data; end
        end
        if (cs_rd) begin rpend_m = 1; r_addr_m = cs_addr; end
        prev_w = cur_w; prev_r = cur_r;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit isw, ok;
        int nwe, nrd, nack, ack_k, exp_k;
        logic [7:0] ack_d;

        tbl[0] = '{1'b1, 25'h0000100, 8'hA5, 3, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 25'h0000200, 8'h3C, 2, 1'b1, 8'h3C, 1'b0};
        tbl[2] = '{1'b0, 25'h1FFFFFF, 8'h00, 1, 1'b1, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 25'h000ABCD, 8'h5A, 8, 1'b1, 8'h5A, 1'b0};
        tbl[4] = '{1'b0, 25'h0001234, 8'h11, 0, 1'b1, 8'hFF, 1'b1};
        tbl[5] = '{1'b1, 25'h0004321, 8'hC3, 0, 1'b0, 8'h00, 1'b1};

        tick();
        for (int i = 0; i < 6; i++) begin
            do_reset();
            check_reset("vec_reset");
            if (tbl[i].wr) begin ld_wr = 1'b1; ld_addr = tbl[i].addr; ld_data = tbl[i].data; end
            else           begin cs_rd = 1'b1; cs_addr = tbl[i].addr; end
            tick();
            ld_wr = 1'b0; cs_rd = 1'b0;
            wait_cmd(isw, ok);
            chk("vec_kind", 32'(isw), 32'(tbl[i].wr));
            chk("vec_addr", 32'(mem_addr), 32'(tbl[i].addr));
            if (tbl[i].wr) chk("vec_din", 32'(mem_din), 32'(tbl[i].data));
            nwe = 0; nrd = 0; nack = 0; ack_k = -1; ack_d = '0;
            for (int k = 1; k <= TMO + 3; k++) begin
                tick();
                nwe += int'(mem_we); nrd += int'(mem_rd);
                if (cs_ack) begin nack++; ack_k = k; ack_d = cs_data; end
                mem_ready = (k == tbl[i].dly);
                mem_dout  = (k == tbl[i].dly) ? tbl[i].data : 8'h77;
            end
            mem_ready = 1'b0;
            exp_k = (tbl[i].dly != 0) ? tbl[i].dly + 1 : TMO + 1;
            chk("vec_nack", 32'(nack), 32'(tbl[i].exp_ack));
            if (tbl[i].exp_ack) begin
                chk("vec_ack_cycle", 32'(ack_k), 32'(exp_k));
                chk("vec_ack_data", 32'(ack_d), 32'(tbl[i].exp_data));
            end
            chk("vec_err_tmo", 32'(err_tmo), 32'(tbl[i].exp_tmo));
            chk("vec_extra_cmd", 32'(nwe + nrd), 0);
            chk("vec_ovf", 32'(ld_ovf), 0);
        end

        // contention from reset, turnaround, and alternation of grants
        do_reset();
        ld_wr = 1'b1; ld_addr = 25'h123; ld_data = 8'h44;
        cs_rd = 1'b1; cs_addr = 25'h456;
        tick();
        ld_wr = 1'b0; cs_rd = 1'b0;
        wait_cmd(isw, ok);
        chk("contend1_first_wr", 32'(isw), 1);
        tick(); mem_ready = 1'b1;
        tick(); mem_ready = 1'b0;
        tick();
        chk("turnaround_rd", 32'(mem_rd), 1);
        chk("turnaround_addr", 32'(mem_addr), 32'h456);
        tick(); mem_ready = 1'b1; mem_dout = 8'h99;
        tick(); mem_ready = 1'b0;
        chk("contend1_ack", 32'(cs_ack), 1);
        chk("contend1_data", 32'(cs_data), 32'h99);
        ld_wr = 1'b1; cs_rd = 1'b1;
        tick();
        ld_wr = 1'b0; cs_rd = 1'b0;
        wait_cmd(isw, ok);
        chk("contend2_first_wr", 32'(isw), 1);
        finish_cmd();
        wait_cmd(isw, ok);
        chk("contend2_then_rd", 32'(isw), 0);
        finish_cmd();
        ld_wr = 1'b1;
        tick();
        ld_wr = 1'b0;
        wait_cmd(isw, ok);
        chk("lone_wr", 32'(isw), 1);
        finish_cmd();
        ld_wr = 1'b1; cs_rd = 1'b1;
        tick();
        ld_wr = 1'b0; cs_rd = 1'b0;
        wait_cmd(isw, ok);
        chk("contend3_first_rd", 32'(isw), 0);
        finish_cmd();
        wait_cmd(isw, ok);
        chk("contend3_then_wr", 32'(isw), 1);
        finish_cmd();

        // refill on the issue cycle, then overflow while WR_WAIT stalls
        do_reset();
        ld_wr = 1'b1; ld_addr = 25'h10; ld_data = 8'h11;
        tick();
        ld_wr = 1'b0;
        wait_cmd(isw, ok);
        chk("ovf_first_din", 32'(mem_din), 32'h11);
        ld_wr = 1'b1; ld_addr = 25'h20; ld_data = 8'h22;
        tick();
        ld_wr = 1'b0;
        chk("iss_refill_no_ovf", 32'(ld_ovf), 0);
        tick();
        ld_wr = 1'b1; ld_addr = 25'h30; ld_data = 8'h33;
        tick();
        ld_wr = 1'b0;
        chk("ovf_set", 32'(ld_ovf), 1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        wait_cmd(isw, ok);
        chk("ovf_kept_addr", 32'(mem_addr), 32'h20);
        chk("ovf_kept_din", 32'(mem_din), 32'h22);
        finish_cmd();
        nwe = 0;
        for (int k = 0; k < 6; k++) begin tick(); nwe += int'(mem_we); end
        chk("ovf_dropped", 32'(nwe), 0);
        chk("ovf_sticky", 32'(ld_ovf), 1);

        // reset during RD_WAIT, then a stray mem_ready
        do_reset();
        cs_rd = 1'b1; cs_addr = 25'h777;
        tick();
        cs_rd = 1'b0;
        wait_cmd(isw, ok);
        tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset("midrst");
        mem_ready = 1'b1; mem_dout = 8'h55;
        tick();
        mem_ready = 1'b0;
        nack = 0; nwe = 0;
        for (int k = 0; k < 4; k++) begin
            nack += int'(cs_ack); nwe += int'(mem_we) + int'(mem_rd);
            tick();
        end
        chk("midrst_no_ack", 32'(nack), 0);
        chk("midrst_no_cmd", 32'(nwe), 0);
        check_reset("midrst_after");

        // random traffic
        do_reset();
        model_init();
        for (int i = 0; i < 3000; i++) begin
            rnd_cycle(1'b1);
            tick();
        end
        for (int i = 0; i < 60; i++) begin
            rnd_cycle(1'b0);
            tick();
        end
        chk("drain_wpend", 32'(wpend_m), 0);
        chk("drain_rpend", 32'(rpend_m), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
